// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI channel arbiter.
// The optional packet statistics are built only when AXI_ARB_STATS_EN is defined.
package axi_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int STAT_W  = 32;
  localparam int MAX_SRC = 16;

  // First set bit of req at or after ptr, wrapping modulo num (num <= MAX_SRC).
  // Both ptr and the loop offset are below num, so one subtraction does the wrap.
  function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [3:0]         ptr,
                                         input int                 num);
    logic [3:0] pick;
    logic       found;
    logic [4:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SRC; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(num)) idx = idx - 5'(num);
      if (!found && (i < num) && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_arb_out_slice.sv
// Two-entry ping-pong output register slice.
// Pointers carry one wrap bit so full/empty are told apart without a counter.
// The input side stays closed for the first cycle after reset (en_q).
module axi_arb_out_slice #(
  parameter int W = 82
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         en_q;
  logic [1:0]   wptr_q;
  logic [1:0]   rptr_q;
  logic [W-1:0] mem_q [2];
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // Occupancy flags and handshake qualifiers; a full slice may still accept
  // when the head is leaving in the same cycle.
  always_comb begin
    full      = (wptr_q[1] != rptr_q[1]) && (wptr_q[0] == rptr_q[0]);
    empty     = (wptr_q == rptr_q);
    out_valid = !empty;
    out_data  = mem_q[rptr_q[0]];
    in_ready  = en_q && (!full || out_ready);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Enable opens one cycle after reset release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) en_q <= 1'b0;
    else        en_q <= 1'b1;
  end

  // Read/write pointers advance on pop/push.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
    end
  end

  // Storage is cleared on reset so the output payload reads zero.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wptr_q[0]] <= in_data;
    end
  end

endmodule

// File: rtl/axi_channel_arbiter.sv
// N:1 round-robin arbiter with packet locking and a 2-entry output slice.
// Optional per-source packet counters: define AXI_ARB_STATS_EN.
//
// Handshake: a beat moves on any channel in a cycle where valid and ready are
// both high. Valid never waits for ready; ready is only raised to the one
// granted source while it is actually requesting, and only when the slice
// can take the beat.
module axi_channel_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int PAYLD_WIDTH = 82,
  parameter int LAST_BIT    = 81
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_SRC-1:0]               valid_src,
  input  logic [NUM_SRC*PAYLD_WIDTH-1:0]   payload_src,
  output logic [NUM_SRC-1:0]               ready_src,
  output logic                             valid_dst,
  output logic [PAYLD_WIDTH-1:0]           payload_dst,
  input  logic                             ready_dst,
  output logic [$clog2(NUM_SRC)-1:0]       grant_id,
  output logic                             busy,
`ifdef AXI_ARB_STATS_EN
  input  logic                             stat_clr,
  output logic [NUM_SRC*STAT_W-1:0]        stat_pkt_cnt,
`endif
  output logic                             state_dbg,
  output logic [$clog2(NUM_SRC)-1:0]       rr_ptr_dbg
);

  localparam int ID_W = $clog2(NUM_SRC);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        lock_id_q, lock_id_d;
  logic [ID_W-1:0]        grant_id_q;
  logic [ID_W-1:0]        pick;
  logic [ID_W-1:0]        next_id;
  logic [NUM_SRC-1:0]     grant_onehot;
  logic                   any_req;
  logic                   slice_ready;
  logic                   slice_en;
  logic                   accept;
  logic [PAYLD_WIDTH-1:0] sel_payload;
  logic                   sel_last;

  // State, priority pointer, lock owner and last grant registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      grant_id_q <= grant_id;
    end
  end

  // Grant selection: locked owner in LOCK, round-robin pick in ARB, otherwise
  // hold the previous id. Nothing is granted until the slice is enabled.
  always_comb begin
    any_req      = |valid_src;
    pick         = ID_W'(rr_pick(MAX_SRC'(valid_src), 4'(rr_ptr_q), NUM_SRC));
    grant_id     = grant_id_q;
    grant_onehot = '0;
    busy         = (state_q == LOCK);
    if (slice_en) begin
      if (state_q == LOCK) begin
        grant_id               = lock_id_q;
        grant_onehot[lock_id_q] = 1'b1;
      end else if (any_req) begin
        grant_id           = pick;
        grant_onehot[pick] = 1'b1;
      end
    end
    ready_src   = grant_onehot & valid_src & {NUM_SRC{slice_ready}};
    accept      = |ready_src;
    sel_payload = payload_src[int'(grant_id)*PAYLD_WIDTH +: PAYLD_WIDTH];
    sel_last    = sel_payload[LAST_BIT];
    next_id     = (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + ID_W'(1);
  end

  // Next state: a non-last beat locks the winner; a last beat releases and
  // moves priority to the source after the winner.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (sel_last) begin
        state_d  = ARB;
        rr_ptr_d = next_id;
      end else begin
        state_d   = LOCK;
        lock_id_d = grant_id;
      end
    end
  end

  // Debug view of the FSM for checkers.
  always_comb begin
    state_dbg  = state_q;
    rr_ptr_dbg = rr_ptr_q;
  end

  axi_arb_out_slice #(
    .W (PAYLD_WIDTH)
  ) u_slice (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (accept),
    .in_data   (sel_payload),
    .in_ready  (slice_ready),
    .out_valid (valid_dst),
    .out_data  (payload_dst),
    .out_ready (ready_dst)
  );

  // Slice enable mirrors the slice's own post-reset gate: any ready at all
  // means the slice is open, and a closed slice reports not-ready even when empty.
  always_comb begin
    slice_en = slice_ready || valid_dst;
  end

`ifdef AXI_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [NUM_SRC];

  // Per-source packet counters: clear has priority, increments saturate.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_SRC; i++) stat_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (stat_clr)
          stat_cnt_q[i] <= '0;
        else if (ready_src[i] && sel_last && (stat_cnt_q[i] != {STAT_W{1'b1}}))
          stat_cnt_q[i] <= stat_cnt_q[i] + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
    assign stat_pkt_cnt[g*STAT_W +: STAT_W] = stat_cnt_q[g];
  end
`endif

endmodule
